seq_run_detector: RTL
=====================

Name: seq_run_detector

Overview:
- Parametrised Mealy run detector for a serial bit stream.
- Asserts a detect pulse when the current valid bit completes a run of RUN_LEN identical bits (all 0s or all 1s).
- Supports runtime overlapping and non-overlapping modes, a registered (Moore-timed) copy of the detect pulse, run-length visibility and a saturating detection counter.
- Sits after a bit deserialiser or sampler and feeds status and interrupt logic.

Parameters:
- RUN_LEN, 2, required run length; legal range 2..(2**CNT_W - 1).
- CNT_W, 4, width of the run-length counter.
- DET_W, 8, width of the detection counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous clear of FSM state and counters.
- overlap  input  1  1 = every bit at or beyond RUN_LEN in a run detects; 0 = run restarts after each detect.
- in_valid  input  1  qualifies in_bit.
- in_bit  input  1  serial data bit.
- det  output  1  Mealy detect, combinational from current state and inputs.
- det_q  output  1  det registered; follows det by exactly 1 cycle.
- run_bit  output  1  value of the bit in the current run.
- run_len  output  CNT_W  length of the current run; 0 in IDLE.
- det_count  output  DET_W  number of detects since reset or clear; saturates.

Behaviour:
- Reset (rst=1, async): state=IDLE, run_len=0, run_bit=0, det_q=0, det_count=0.
- det is forced 0 while rst=1.
- States:
  - IDLE: no run in progress.
  - RUN: tracking a run of run_bit of length run_len (>= 1).
- Next length on a valid bit:
  - L' = run_len+1 if state=RUN and in_bit=run_bit; otherwise L' = 1.
  - The increment saturates at 2**CNT_W-1; no wrap-around.
- det is 1 only when in_valid=1 and clear=0, and:
  - overlap=1: L' >= RUN_LEN.
  - overlap=0: L' == RUN_LEN.
- Transitions (only when in_valid=1 and clear=0):
  - Default: state=RUN, run_bit=in_bit, run_len=L'.
  - If overlap=0 and det=1: state=IDLE, run_len=0, run_bit holds. The next valid bit starts a fresh run of length 1, even if it equals run_bit.
- in_valid=0: state, run_len, run_bit and det_count hold; det=0. Gaps do not break a run.
- clear=1:
  - Next edge: state=IDLE, run_len=0, run_bit=0, det_count=0.
  - det=0 in the clear cycle; det_q takes 0 on that edge.
  - clear overrides in_valid.
- det_count:
  - Increments by 1 on each edge where det=1.
  - Holds at 2**DET_W-1 once reached.
- det_q <= det every edge, so det_q=1 exactly one cycle after det=1.
- overlap is sampled each cycle. A change mid-run applies from that cycle using the current run_len; no state is flushed.
- Saturated run_len with overlap=1 keeps detecting on every further matching bit.
- rst asserted mid-run returns immediately to reset values; the first valid bit after release starts a run of length 1.
- Latency: det is 0 cycles from in_bit; det_q and det_count are 1 cycle.

Decomposition:
- Shared constants file holds:
  - state encodings ST_IDLE=1'b0 and ST_RUN=1'b1;
  - default RUN_LEN, CNT_W and DET_W values.
- One sub-module, sat_counter: parametrised width, with clear, enable and increment ports and a saturating value output.
  - Instantiated twice: run length (with load-to-1 option) and det_count.
- The FSM and detect logic stay in the top level.

Test Plan:
- RUN_LEN=2, overlap=1, bits 0,0,0,1,1,0 all valid:
  - det = 0,1,1,0,1,0;
  - det_q is the same sequence one cycle later;
  - det_count ends at 3.
- RUN_LEN=3, overlap=0, eight consecutive 1s:
  - det pulses on bits 3 and 6 only; run_len after bit 3 is 0, after bit 4 is 1;
  - det_count=2.
- RUN_LEN=2, bits 1,(in_valid=0 for 3 cycles),1:
  - det=0 during the gap and 1 on the second valid 1;
  - run_len holds 1 through the gap.
- CNT_W=2, RUN_LEN=3, overlap=1, six 0s:
  - run_len saturates at 3;
  - det=1 on bits 3..6;
  - det_count=4.
- DET_W=2, RUN_LEN=2, overlap=1, ten 1s: det_count saturates at 3 and holds.
- clear asserted together with a completing bit: det=0 that cycle, then det_count=0 and run_len=0. Then rst asserted mid-run: all outputs go to reset values asynchronously.

Source files
------------

// File: rtl/seq_run_detector_pkg.sv
// seq_run_detector_pkg: shared state encodings and default sizes for the run detector
package seq_run_detector_pkg;
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;
  localparam int RUN_LEN_DEF = 2;
  localparam int CNT_W_DEF   = 4;
  localparam int DET_W_DEF   = 8;
endpackage

// File: rtl/seq_run_detector_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear and optional load-to-1
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         en_i,
  input  logic         load_i,
  output logic [W-1:0] value_o,
  output logic [W-1:0] inc_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign inc_o   = &cnt_q ? cnt_q : cnt_q + 1'b1;
  assign value_o = cnt_q;
  // clear beats enable; load restarts the count at 1 instead of incrementing
  always_comb cnt_d = clear_i ? '0 : !en_i ? cnt_q : load_i ? W'(1) : inc_o;
  // count register
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
endmodule

// File: rtl/seq_run_detector.sv
// seq_run_detector: Mealy detector for runs of RUN_LEN identical bits with saturating counters
module seq_run_detector
  import seq_run_detector_pkg::*;
#(
  parameter int RUN_LEN = RUN_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DET_W   = DET_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             overlap,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             det,
  output logic             det_q,
  output logic             run_bit,
  output logic [CNT_W-1:0] run_len,
  output logic [DET_W-1:0] det_count
);
  state_e           state_q;
  logic             run_bit_q, det_q_q;
  logic             take, extend, restart;
  logic [CNT_W-1:0] run_inc, len_nxt;
  logic [DET_W-1:0] det_inc;
  assign take    = in_valid & ~clear;
  assign extend  = (state_q == ST_RUN) & (in_bit == run_bit_q);
  assign len_nxt = extend ? run_inc : CNT_W'(1);
  assign det     = ~rst & take & (overlap ? len_nxt >= CNT_W'(RUN_LEN) : len_nxt == CNT_W'(RUN_LEN));
  assign restart = take & det & ~overlap;
  assign run_bit = run_bit_q;
  assign det_q   = det_q_q;
  sat_counter #(.W(CNT_W)) u_run_len (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear | restart),
    .en_i    (take),
    .load_i  (~extend),
    .value_o (run_len),
    .inc_o   (run_inc)
  );
  sat_counter #(.W(DET_W)) u_det_count (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear),
    .en_i    (det),
    .load_i  (1'b0),
    .value_o (det_count),
    .inc_o   (det_inc)
  );
  // run FSM; a non-overlapping detect drops back to IDLE so the next bit starts afresh
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= ST_IDLE;
      run_bit_q <= 1'b0;
      det_q_q   <= 1'b0;
    end else begin
      det_q_q <= det;
      if (clear) begin
        state_q   <= ST_IDLE;
        run_bit_q <= 1'b0;
      end else if (take) begin
        state_q   <= restart ? ST_IDLE : ST_RUN;
        run_bit_q <= in_bit;
      end
    end
  logic unused_det_inc;
  assign unused_det_inc = ^det_inc;
endmodule
